// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS memory access path.
package mips_pkg;

    // Memory sequencer states
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    // Kind of access currently latched
    typedef enum logic [1:0] {
        ACC_FETCH = 2'd0,
        ACC_RD    = 2'd1,
        ACC_WR    = 2'd2
    } acc_e;

    // Low address bits that must be zero for a word access
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge bus between the access unit and the unified memory.
interface mem_access_unit_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/mem_access_unit_timeout_cnt.sv
// Wait-cycle counter for an outstanding memory request; tc flags the
// cycle in which the count would reach TIMEOUT.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic res,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // Clear on request entry, count each unacknowledged cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal when this is the TIMEOUT-th cycle with the request unanswered
    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_access_unit.sv
// Sequences fetch/load/store accesses to the unified memory for the
// multicycle core; owns PC, IR and MDR and reports completion and errors.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 15,
    parameter logic [DATA_W-1:0] PC_RESET = '0
) (
    input  logic              clk,
    input  logic              res,
    input  logic              fetch_req,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic              pc_en,
    input  logic [DATA_W-1:0] pc_next,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              err_clr,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic              err_align,
    output logic              err_overrun,
    mem_access_unit_if.master mem
);

    state_e            state_q, state_d;
    acc_e              acc_q, acc_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              done_q, done_d;
    logic              err_to_q, err_al_q, err_ov_q;
    logic              set_to, set_al, set_ov;

    acc_e              sel_acc;
    logic [DATA_W-1:0] sel_addr;
    logic              any_req;
    logic              cnt_clr, cnt_en, cnt_tc;

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk (clk),
        .res (res),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (cnt_tc)
    );

    assign any_req = fetch_req | rd_req | wr_req;

    // Request arbitration: store beats load beats fetch; fetch uses current pc
    always_comb begin
        sel_acc  = ACC_FETCH;
        sel_addr = pc_q;
        if (wr_req) begin
            sel_acc  = ACC_WR;
            sel_addr = alu_out;
        end else if (rd_req) begin
            sel_acc  = ACC_RD;
            sel_addr = alu_out;
        end
    end

    // Sequencer next state, bus controls, capture and error events
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        done_d  = 1'b0;
        set_to  = 1'b0;
        set_al  = 1'b0;
        set_ov  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    // every request that loses arbitration is reported
                    set_ov = (wr_req & (rd_req | fetch_req)) | (rd_req & fetch_req);
                    if (is_misaligned(sel_addr[1:0])) begin
                        // refused without touching memory; still completes
                        set_al = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        acc_d   = sel_acc;
                        req_d   = 1'b1;
                        we_d    = (sel_acc == ACC_WR);
                        addr_d  = sel_addr;
                        wdata_d = wr_data;
                        cnt_clr = 1'b1;
                    end
                end
            end
            REQ: begin
                set_ov = any_req;
                if (mem.ack) begin
                    // ack beats a simultaneous timeout
                    if (acc_q == ACC_FETCH) ir_d  = mem.rdata;
                    if (acc_q == ACC_RD)    mdr_d = mem.rdata;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_tc) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    set_to  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer, bus and data registers; reset discards any access in flight
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            acc_q    <= ACC_FETCH;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ir_q     <= '0;
            mdr_q    <= '0;
            done_q   <= 1'b0;
            err_to_q <= 1'b0;
            err_al_q <= 1'b0;
            err_ov_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            done_q   <= done_d;
            // a new error outranks a same-cycle clear
            err_to_q <= set_to | (err_to_q & ~err_clr);
            err_al_q <= set_al | (err_al_q & ~err_clr);
            err_ov_q <= set_ov | (err_ov_q & ~err_clr);
        end
    end

    // PC loads independently of the sequencer; a latched fetch keeps its address
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pc_q <= PC_RESET;
        end else if (pc_en) begin
            pc_q <= pc_next;
        end
    end

    assign mem.req   = req_q;
    assign mem.we    = we_q;
    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;

    assign pc          = pc_q;
    assign instr       = ir_q;
    assign mem_data    = mdr_q;
    assign done        = done_q;
    assign err_timeout = err_to_q;
    assign err_align   = err_al_q;
    assign err_overrun = err_ov_q;
    assign busy        = (state_q != IDLE) | any_req;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single accesses plus
// hand sequences for timeout, overrun, error/clear races and reset.
module tb_mem_access_unit;

    localparam int K_FETCH = 0;
    localparam int K_RD    = 1;
    localparam int K_WR    = 2;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        fetch_req = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
    logic        pc_en = 1'b0, err_clr = 1'b0;
    logic [31:0] pc_next = '0, alu_out = '0, wr_data = '0;
    logic [31:0] pc, instr, mem_data;
    logic        busy, done, err_timeout, err_align, err_overrun;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit_if #(.DATA_W(32)) mif ();

    mem_access_unit #(
        .DATA_W   (32),
        .TIMEOUT  (15),
        .PC_RESET (32'h0)
    ) dut (
        .clk         (clk),
        .res         (res),
        .fetch_req   (fetch_req),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .pc_en       (pc_en),
        .pc_next     (pc_next),
        .alu_out     (alu_out),
        .wr_data     (wr_data),
        .err_clr     (err_clr),
        .pc          (pc),
        .instr       (instr),
        .mem_data    (mem_data),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .err_align   (err_align),
        .err_overrun (err_overrun),
        .mem         (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc_val;
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        int          exp_lat;
        int          exp_reqc;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_instr;
        logic [31:0] exp_mdr;
        logic        exp_align;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Runs from the cycle after the request pulse until done (bounded).
    // ack_at: acknowledge on this req cycle (1 = first); 0 = never.
    task automatic run_txn(input int ack_at, input logic [31:0] rdata,
                           output int lat, output int reqc,
                           output logic [31:0] a0, output logic we0,
                           output logic [31:0] wd0, output logic stable);
        logic got;
        got = 1'b0; lat = 1; reqc = 0; a0 = '0; we0 = 1'b0; wd0 = '0; stable = 1'b1;
        while (lat <= 40 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (mif.req) begin
                    reqc++;
                    if (reqc == 1) begin
                        a0 = mif.addr; we0 = mif.we; wd0 = mif.wdata;
                    end else if (mif.addr !== a0 || mif.we !== we0 || mif.wdata !== wd0) begin
                        stable = 1'b0;
                    end
                end
                mif.ack   = mif.req && (reqc == ack_at);
                mif.rdata = rdata;
                step();
                mif.ack = 1'b0;
                lat++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int          lat, reqc;
        logic [31:0] a0, wd0;
        logic        we0, stable;
        logic [31:0] m_instr;

        //            pc_val        kind     addr          wdata         w  rdata         lat reqc addr          we    instr         mdr           align
        vecs[0] = '{32'h0000_0000, K_FETCH, 32'h0,        32'h0,        0, 32'h8C01_0004, 2,  1,  32'h0000_0000, 1'b0, 32'h8C01_0004, 32'h0,        1'b0};
        vecs[1] = '{32'h0000_0004, K_WR,    32'h0000_0010, 32'hDEAD_BEEF, 3, 32'h0,        5,  4,  32'h0000_0010, 1'b1, 32'h8C01_0004, 32'h0,        1'b0};
        vecs[2] = '{32'h0000_0008, K_RD,    32'h0000_0020, 32'h0,        1, 32'h1234_5678, 3,  2,  32'h0000_0020, 1'b0, 32'h8C01_0004, 32'h1234_5678, 1'b0};
        vecs[3] = '{32'h0000_000C, K_RD,    32'h0000_0012, 32'h0,        0, 32'hFFFF_FFFF, 1,  0,  32'h0,        1'b0, 32'h8C01_0004, 32'h1234_5678, 1'b1};
        vecs[4] = '{32'h0000_0100, K_FETCH, 32'h0,        32'h0,        2, 32'hAABB_CCDD, 4,  3,  32'h0000_0100, 1'b0, 32'hAABB_CCDD, 32'h1234_5678, 1'b0};
        vecs[5] = '{32'h0000_0102, K_FETCH, 32'h0,        32'h0,        0, 32'h1111_1111, 1,  0,  32'h0,        1'b0, 32'hAABB_CCDD, 32'h1234_5678, 1'b1};
        vecs[6] = '{32'h0000_0104, K_WR,    32'hFFFF_FFFC, 32'h0BAD_F00D, 0, 32'h0,        2,  1,  32'hFFFF_FFFC, 1'b1, 32'hAABB_CCDD, 32'h1234_5678, 1'b0};

        mif.ack = 1'b0;
        mif.rdata = '0;

        // reset state
        step(); step();
        check("rst pc", pc, 32'h0);
        check("rst instr", instr, 32'h0);
        check("rst mem_data", mem_data, 32'h0);
        check("rst mem_req", mif.req, 32'h0);
        check("rst done", done, 32'h0);
        check("rst busy", busy, 32'h0);
        #3 res = 1'b1;
        step();

        // table of single accesses
        for (int i = 0; i < 7; i++) begin
            pc_en = 1'b1; pc_next = vecs[i].pc_val;
            step();
            pc_en = 1'b0;
            check($sformatf("v%0d pc", i), pc, vecs[i].pc_val);
            fetch_req = (vecs[i].kind == K_FETCH);
            rd_req    = (vecs[i].kind == K_RD);
            wr_req    = (vecs[i].kind == K_WR);
            alu_out   = vecs[i].addr;
            wr_data   = vecs[i].wdata;
            #1 check($sformatf("v%0d busy", i), busy, 32'h1);
            step();
            fetch_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
            run_txn(vecs[i].waits + 1, vecs[i].rdata, lat, reqc, a0, we0, wd0, stable);
            check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d req cycles", i), reqc, vecs[i].exp_reqc);
            if (vecs[i].exp_reqc > 0) begin
                check($sformatf("v%0d addr", i), a0, vecs[i].exp_addr);
                check($sformatf("v%0d we", i), we0, vecs[i].exp_we);
                check($sformatf("v%0d stable", i), stable, 32'h1);
                if (vecs[i].exp_we)
                    check($sformatf("v%0d wdata", i), wd0, vecs[i].wdata);
            end
            check($sformatf("v%0d instr", i), instr, vecs[i].exp_instr);
            check($sformatf("v%0d mem_data", i), mem_data, vecs[i].exp_mdr);
            check($sformatf("v%0d err_align", i), err_align, vecs[i].exp_align);
            check($sformatf("v%0d err_timeout", i), err_timeout, 32'h0);
            check($sformatf("v%0d mem_req after", i), mif.req, 32'h0);
            step();
            check($sformatf("v%0d done single", i), done, 32'h0);
            err_clr = 1'b1;
            step();
            err_clr = 1'b0;
            check($sformatf("v%0d err_align clr", i), err_align, 32'h0);
        end
        m_instr = vecs[6].exp_instr;

        // timeout: fetch never acknowledged
        pc_en = 1'b1; pc_next = 32'h40;
        step();
        pc_en = 1'b0; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        run_txn(0, 32'h0, lat, reqc, a0, we0, wd0, stable);
        check("tmo req cycles", reqc, 32'd15);
        check("tmo latency", lat, 32'd16);
        check("tmo addr", a0, 32'h40);
        check("tmo err_timeout", err_timeout, 32'h1);
        check("tmo instr", instr, m_instr);
        check("tmo mem_req", mif.req, 32'h0);

        // clear racing a new alignment error: error stays, old timeout clears
        rd_req = 1'b1; alu_out = 32'h21; err_clr = 1'b1;
        step();
        rd_req = 1'b0; err_clr = 1'b0;
        check("race err_align", err_align, 32'h1);
        check("race err_timeout", err_timeout, 32'h0);
        check("race done", done, 32'h1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("race cleared", err_align, 32'h0);

        // ack arriving on the terminal cycle completes normally
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        run_txn(15, 32'hCAFE_F00D, lat, reqc, a0, we0, wd0, stable);
        check("tmo-ack latency", lat, 32'd16);
        check("tmo-ack instr", instr, 32'hCAFE_F00D);
        check("tmo-ack err_timeout", err_timeout, 32'h0);
        step();

        // fetch+read together, then a write while busy
        alu_out = 32'h30; fetch_req = 1'b1; rd_req = 1'b1;
        step();
        fetch_req = 1'b0; rd_req = 1'b0;
        check("ovr err_overrun", err_overrun, 32'h1);
        check("ovr mem_req", mif.req, 32'h1);
        check("ovr addr", mif.addr, 32'h30);
        check("ovr we", mif.we, 32'h0);
        wr_req = 1'b1; alu_out = 32'h44; wr_data = 32'h11; err_clr = 1'b1;
        step();
        wr_req = 1'b0; err_clr = 1'b0;
        check("ovr busy-drop flag", err_overrun, 32'h1);
        check("ovr addr held", mif.addr, 32'h30);
        check("ovr we held", mif.we, 32'h0);
        mif.ack = 1'b1; mif.rdata = 32'h55AA_55AA;
        step();
        mif.ack = 1'b0;
        check("ovr done", done, 32'h1);
        check("ovr mem_data", mem_data, 32'h55AA_55AA);
        check("ovr instr", instr, 32'hCAFE_F00D);
        step();
        check("ovr no write", mif.req, 32'h0);
        // stray ack while idle
        mif.ack = 1'b1; mif.rdata = 32'h9999_9999;
        step();
        mif.ack = 1'b0;
        check("stray done", done, 32'h0);
        check("stray mem_req", mif.req, 32'h0);
        check("stray mem_data", mem_data, 32'h55AA_55AA);

        // asynchronous reset in the middle of a request
        pc_en = 1'b1; pc_next = 32'h200;
        step();
        pc_en = 1'b0;
        check("rst2 pc loaded", pc, 32'h200);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("rst2 mem_req pre", mif.req, 32'h1);
        #2 res = 1'b0;
        #1;
        check("rst2 mem_req", mif.req, 32'h0);
        check("rst2 pc", pc, 32'h0);
        check("rst2 instr", instr, 32'h0);
        check("rst2 mem_data", mem_data, 32'h0);
        check("rst2 err_overrun", err_overrun, 32'h0);
        #2 res = 1'b1;
        step();
        check("rst2 idle req", mif.req, 32'h0);
        check("rst2 idle done", done, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
